mips_multicycle_ctrl: RTL and testbench

- Multicycle control FSM that sequences the MIPS datapath. It decodes opcode/func from the datapath and drives all datapath control lines, one instruction phase per state.
- Adds PC and IR write enables, a memory ready handshake with timeout, an illegal-instruction trap and a retired-instruction counter.
- Sits beside the datapath at the CPU top level and replaces the single-cycle combinational control.

---
 rtl/mips_multicycle_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// with a memory-ready timeout, an illegal-instruction trap and a retire counter.
module mips_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             PCSrc,
    output logic             RegDst,
    output logic             ALUSrc,
    output logic             MemToReg,
    output logic             regWrite,
    output logic             MemWrite,
    output logic             MemRead,
    output logic [2:0]       ALUOp,
    output logic             instr_done,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       o_dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_WB_R   = 4'd4,
        S_EXEC_I = 4'd5,
        S_WB_I   = 4'd6,
        S_ADDR   = 4'd7,
        S_MEM_RD = 4'd8,
        S_WB_LW  = 4'd9,
        S_MEM_WR = 4'd10,
        S_BRANCH = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next;
    logic [5:0]       r_opc_q;
    logic [5:0]       r_func_q;
    logic [7:0]       r_wait;
    logic [1:0]       r_trap_cause;
    logic [CNT_W-1:0] r_instr_count;
    logic             w_retire;
    logic             w_set_cause;
    logic [1:0]       w_cause_d;
    logic [3:0]       w_dec_live;
    logic [3:0]       w_dec_q;

    // Returns {legal, ALUOp} for an R-type function field.
    function automatic logic [3:0] dec_func(input logic [5:0] f);
        case (f)
            6'b100000: dec_func = 4'b1_000;
            6'b100010: dec_func = 4'b1_001;
            6'b100100: dec_func = 4'b1_010;
            6'b100101: dec_func = 4'b1_011;
            6'b101010: dec_func = 4'b1_100;
            default:   dec_func = 4'b0_000;
        endcase
    endfunction

    assign w_dec_live = dec_func(func);
    assign w_dec_q    = dec_func(r_func_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_opc_q       <= '0;
            r_func_q      <= '0;
            r_wait        <= '0;
            r_trap_cause  <= '0;
            r_instr_count <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_opc_q  <= opcode;
                r_func_q <= func;
            end
            if (r_state == S_ADDR)
                r_wait <= '0;
            else if ((r_state == S_MEM_RD || r_state == S_MEM_WR) && !mem_ready)
                r_wait <= r_wait + 8'd1;
            if (w_set_cause)
                r_trap_cause <= w_cause_d;
            if (w_retire)
                r_instr_count <= r_instr_count + 1'b1;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_retire    = 1'b0;
        w_set_cause = 1'b0;
        w_cause_d   = 2'b00;
        PCWrite     = 1'b0;
        IRWrite     = 1'b0;
        PCSrc       = 1'b0;
        RegDst      = 1'b0;
        ALUSrc      = 1'b0;
        MemToReg    = 1'b0;
        regWrite    = 1'b0;
        MemWrite    = 1'b0;
        MemRead     = 1'b0;
        ALUOp       = 3'b000;
        trap        = 1'b0;
        case (r_state)
            S_IDLE:   if (run) w_next = S_FETCH;
            S_FETCH: begin
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                w_next  = S_DECODE;
            end
            // Dispatch uses the live fields; they are latched on this same edge.
            S_DECODE: begin
                case (opcode)
                    OP_R: begin
                        if (w_dec_live[3]) begin
                            w_next = S_EXEC_R;
                        end else begin
                            w_next      = S_TRAP;
                            w_set_cause = 1'b1;
                            w_cause_d   = 2'b10;
                        end
                    end
                    OP_LW, OP_SW: w_next = S_ADDR;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_EXEC_I;
                    default: begin
                        w_next      = S_TRAP;
                        w_set_cause = 1'b1;
                        w_cause_d   = 2'b01;
                    end
                endcase
            end
            S_EXEC_R: begin
                ALUOp  = w_dec_q[2:0];
                w_next = S_WB_R;
            end
            S_WB_R: begin
                ALUOp    = w_dec_q[2:0];
                RegDst   = 1'b1;
                regWrite = 1'b1;
                w_retire = 1'b1;
            end
            S_EXEC_I: begin
                ALUSrc = 1'b1;
                w_next = S_WB_I;
            end
            S_WB_I: begin
                ALUSrc   = 1'b1;
                regWrite = 1'b1;
                w_retire = 1'b1;
            end
            S_ADDR: begin
                ALUSrc = 1'b1;
                w_next = (r_opc_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                ALUSrc  = 1'b1;
                MemRead = 1'b1;
                if (mem_ready) begin
                    w_next = S_WB_LW;
                end else if (r_wait == WAIT_LAST) begin
                    w_next      = S_TRAP;
                    w_set_cause = 1'b1;
                    w_cause_d   = 2'b11;
                end
            end
            S_WB_LW: begin
                ALUSrc   = 1'b1;
                MemToReg = 1'b1;
                regWrite = 1'b1;
                w_retire = 1'b1;
            end
            S_MEM_WR: begin
                ALUSrc   = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) begin
                    w_retire = 1'b1;
                end else if (r_wait == WAIT_LAST) begin
                    w_next      = S_TRAP;
                    w_set_cause = 1'b1;
                    w_cause_d   = 2'b11;
                end
            end
            S_BRANCH: begin
                ALUOp    = 3'b001;
                PCSrc    = 1'b1;
                PCWrite  = Zero;
                w_retire = 1'b1;
            end
            S_TRAP:   trap = 1'b1;
            default:  w_next = S_IDLE;
        endcase
        if (w_retire)
            w_next = run ? S_FETCH : S_IDLE;
    end

    assign instr_done  = w_retire;
    assign trap_cause  = r_trap_cause;
    assign instr_count = r_instr_count;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: per-cycle state and control-vector
// checks against hand-computed values for each instruction class and fault path.
module tb_mips_multicycle_ctrl;
    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 15;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_EXEC_R = 4'd3;
    localparam logic [3:0] S_WB_R   = 4'd4;
    localparam logic [3:0] S_EXEC_I = 4'd5;
    localparam logic [3:0] S_WB_I   = 4'd6;
    localparam logic [3:0] S_ADDR   = 4'd7;
    localparam logic [3:0] S_MEM_RD = 4'd8;
    localparam logic [3:0] S_WB_LW  = 4'd9;
    localparam logic [3:0] S_MEM_WR = 4'd10;
    localparam logic [3:0] S_BRANCH = 4'd11;
    localparam logic [3:0] S_TRAP   = 4'd12;

    // Order: PCWrite IRWrite PCSrc RegDst ALUSrc MemToReg regWrite MemWrite MemRead ALUOp[2:0] instr_done
    localparam logic [12:0] C_NONE    = 13'b0_0_0_0_0_0_0_0_0_000_0;
    localparam logic [12:0] C_FETCH   = 13'b1_1_0_0_0_0_0_0_0_000_0;
    localparam logic [12:0] C_EXR_SUB = 13'b0_0_0_0_0_0_0_0_0_001_0;
    localparam logic [12:0] C_WBR_SUB = 13'b0_0_0_1_0_0_1_0_0_001_1;
    localparam logic [12:0] C_EXR_SLT = 13'b0_0_0_0_0_0_0_0_0_100_0;
    localparam logic [12:0] C_WBR_SLT = 13'b0_0_0_1_0_0_1_0_0_100_1;
    localparam logic [12:0] C_ADDR    = 13'b0_0_0_0_1_0_0_0_0_000_0;
    localparam logic [12:0] C_MRD     = 13'b0_0_0_0_1_0_0_0_1_000_0;
    localparam logic [12:0] C_WBLW    = 13'b0_0_0_0_1_1_1_0_0_000_1;
    localparam logic [12:0] C_MWR     = 13'b0_0_0_0_1_0_0_1_0_000_0;
    localparam logic [12:0] C_MWR_D   = 13'b0_0_0_0_1_0_0_1_0_000_1;
    localparam logic [12:0] C_BR_T    = 13'b1_0_1_0_0_0_0_0_0_001_1;
    localparam logic [12:0] C_BR_N    = 13'b0_0_1_0_0_0_0_0_0_001_1;
    localparam logic [12:0] C_EXI     = 13'b0_0_0_0_1_0_0_0_0_000_0;
    localparam logic [12:0] C_WBI     = 13'b0_0_0_0_1_0_1_0_0_000_1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic run = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] func = '0;
    logic Zero = 1'b0;
    logic mem_ready = 1'b0;
    logic PCWrite, IRWrite, PCSrc, RegDst, ALUSrc, MemToReg, regWrite, MemWrite, MemRead;
    logic [2:0] ALUOp;
    logic instr_done, trap;
    logic [1:0] trap_cause;
    logic [CNT_W-1:0] instr_count;
    logic [3:0] o_dbg_state;
    logic [12:0] ctrl;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .func(func),
        .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .PCSrc(PCSrc), .RegDst(RegDst), .ALUSrc(ALUSrc), .MemToReg(MemToReg),
        .regWrite(regWrite), .MemWrite(MemWrite), .MemRead(MemRead), .ALUOp(ALUOp),
        .instr_done(instr_done), .trap(trap), .trap_cause(trap_cause),
        .instr_count(instr_count), .o_dbg_state(o_dbg_state)
    );

    assign ctrl = {PCWrite, IRWrite, PCSrc, RegDst, ALUSrc, MemToReg, regWrite,
                   MemWrite, MemRead, ALUOp, instr_done};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: sample state/controls at the falling edge, then move to just after the next rise.
    task automatic cyc(input string tag, input logic [3:0] st, input logic [12:0] c);
        @(negedge clk);
        check({tag, "_state"}, 32'(o_dbg_state), 32'(st));
        check({tag, "_ctrl"}, 32'(ctrl), 32'(c));
        check({tag, "_excl"}, 32'(int'(regWrite) + int'(MemWrite) + int'(MemRead) > 1), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        run = 1'b0;
        mem_ready = 1'b0;
        Zero = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_state", 32'(o_dbg_state), 32'(S_IDLE));
        check("rst_ctrl", 32'(ctrl), 32'(C_NONE));
        check("rst_trap", 32'(trap), 32'd0);
        check("rst_cause", 32'(trap_cause), 32'd0);
        check("rst_count", 32'(instr_count), 32'd0);
        do_reset();

        // R-type sub; fields scrambled after DECODE to prove latching, run dropped mid-instruction
        run = 1'b1; opcode = 6'b000000; func = 6'b100010;
        cyc("sub_idle", S_IDLE, C_NONE);
        run = 1'b0;
        cyc("sub_fetch", S_FETCH, C_FETCH);
        cyc("sub_dec", S_DECODE, C_NONE);
        opcode = 6'b111111; func = 6'b000000;
        cyc("sub_ex", S_EXEC_R, C_EXR_SUB);
        cyc("sub_wb", S_WB_R, C_WBR_SUB);
        check("sub_count", 32'(instr_count), 32'd1);

        // R-type slt
        run = 1'b1; opcode = 6'b000000; func = 6'b101010;
        cyc("slt_idle", S_IDLE, C_NONE);
        run = 1'b0;
        cyc("slt_fetch", S_FETCH, C_FETCH);
        cyc("slt_dec", S_DECODE, C_NONE);
        cyc("slt_ex", S_EXEC_R, C_EXR_SLT);
        cyc("slt_wb", S_WB_R, C_WBR_SLT);
        check("slt_count", 32'(instr_count), 32'd2);

        // lw with two wait cycles; mem_ready high early is ignored outside MEM_RD
        run = 1'b1; opcode = 6'b100011;
        cyc("lw_idle", S_IDLE, C_NONE);
        run = 1'b0; mem_ready = 1'b1;
        cyc("lw_fetch", S_FETCH, C_FETCH);
        cyc("lw_dec", S_DECODE, C_NONE);
        opcode = 6'b000100;
        cyc("lw_addr", S_ADDR, C_ADDR);
        mem_ready = 1'b0;
        cyc("lw_rd0", S_MEM_RD, C_MRD);
        cyc("lw_rd1", S_MEM_RD, C_MRD);
        mem_ready = 1'b1;
        cyc("lw_rd2", S_MEM_RD, C_MRD);
        mem_ready = 1'b0;
        cyc("lw_wb", S_WB_LW, C_WBLW);
        check("lw_count", 32'(instr_count), 32'd3);

        // Back-to-back beq: taken then not taken
        run = 1'b1; opcode = 6'b000100;
        cyc("beq_idle", S_IDLE, C_NONE);
        cyc("beq1_fetch", S_FETCH, C_FETCH);
        cyc("beq1_dec", S_DECODE, C_NONE);
        Zero = 1'b1;
        cyc("beq1_br", S_BRANCH, C_BR_T);
        Zero = 1'b0;
        cyc("beq2_fetch", S_FETCH, C_FETCH);
        cyc("beq2_dec", S_DECODE, C_NONE);
        run = 1'b0;
        cyc("beq2_br", S_BRANCH, C_BR_N);
        check("beq_count", 32'(instr_count), 32'd5);
        check("beq_idle_after", 32'(o_dbg_state), 32'(S_IDLE));

        // addi
        run = 1'b1; opcode = 6'b001000;
        cyc("addi_idle", S_IDLE, C_NONE);
        run = 1'b0;
        cyc("addi_fetch", S_FETCH, C_FETCH);
        cyc("addi_dec", S_DECODE, C_NONE);
        cyc("addi_ex", S_EXEC_I, C_EXI);
        cyc("addi_wb", S_WB_I, C_WBI);
        check("addi_count", 32'(instr_count), 32'd6);

        // sw with one wait cycle
        run = 1'b1; opcode = 6'b101011;
        cyc("sw_idle", S_IDLE, C_NONE);
        run = 1'b0;
        cyc("sw_fetch", S_FETCH, C_FETCH);
        cyc("sw_dec", S_DECODE, C_NONE);
        cyc("sw_addr", S_ADDR, C_ADDR);
        cyc("sw_wr0", S_MEM_WR, C_MWR);
        mem_ready = 1'b1;
        cyc("sw_wr1", S_MEM_WR, C_MWR_D);
        mem_ready = 1'b0;
        check("sw_count", 32'(instr_count), 32'd7);

        // sw timeout: MemWrite for exactly MEM_TIMEOUT cycles, then sticky trap
        run = 1'b1; opcode = 6'b101011;
        cyc("swto_idle", S_IDLE, C_NONE);
        run = 1'b0;
        cyc("swto_fetch", S_FETCH, C_FETCH);
        cyc("swto_dec", S_DECODE, C_NONE);
        cyc("swto_addr", S_ADDR, C_ADDR);
        for (int i = 0; i < MEM_TIMEOUT; i++)
            cyc($sformatf("swto_wr%0d", i), S_MEM_WR, C_MWR);
        run = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc($sformatf("swto_trap%0d", i), S_TRAP, C_NONE);
            check($sformatf("swto_flag%0d", i), 32'(trap), 32'd1);
            check($sformatf("swto_cause%0d", i), 32'(trap_cause), 32'd3);
        end
        check("swto_count", 32'(instr_count), 32'd7);
        do_reset();
        check("swto_rst_trap", 32'(trap), 32'd0);
        check("swto_rst_cause", 32'(trap_cause), 32'd0);
        check("swto_rst_count", 32'(instr_count), 32'd0);

        // addi to make the count nonzero, then asynchronous reset during MEM_RD
        run = 1'b1; opcode = 6'b001000;
        cyc("pre_idle", S_IDLE, C_NONE);
        opcode = 6'b100011;
        cyc("pre_fetch", S_FETCH, C_FETCH);
        run = 1'b0; opcode = 6'b001000;
        cyc("pre_dec", S_DECODE, C_NONE);
        cyc("pre_ex", S_EXEC_I, C_EXI);
        run = 1'b1;
        cyc("pre_wb", S_WB_I, C_WBI);
        check("pre_count", 32'(instr_count), 32'd1);
        run = 1'b0; opcode = 6'b100011;
        cyc("ar_fetch", S_FETCH, C_FETCH);
        cyc("ar_dec", S_DECODE, C_NONE);
        cyc("ar_addr", S_ADDR, C_ADDR);
        #2;
        check("ar_in_rd", 32'(o_dbg_state), 32'(S_MEM_RD));
        check("ar_memread", 32'(MemRead), 32'd1);
        reset = 1'b0;
        #1;
        check("ar_state", 32'(o_dbg_state), 32'(S_IDLE));
        check("ar_ctrl", 32'(ctrl), 32'(C_NONE));
        check("ar_count", 32'(instr_count), 32'd0);
        do_reset();

        // Illegal opcode
        run = 1'b1; opcode = 6'b111111;
        cyc("iop_idle", S_IDLE, C_NONE);
        run = 1'b0;
        cyc("iop_fetch", S_FETCH, C_FETCH);
        cyc("iop_dec", S_DECODE, C_NONE);
        cyc("iop_trap", S_TRAP, C_NONE);
        check("iop_flag", 32'(trap), 32'd1);
        check("iop_cause", 32'(trap_cause), 32'd1);
        do_reset();

        // Illegal R-type func: no register write ever
        run = 1'b1; opcode = 6'b000000; func = 6'b000000;
        cyc("ifn_idle", S_IDLE, C_NONE);
        run = 1'b0;
        cyc("ifn_fetch", S_FETCH, C_FETCH);
        cyc("ifn_dec", S_DECODE, C_NONE);
        cyc("ifn_trap0", S_TRAP, C_NONE);
        cyc("ifn_trap1", S_TRAP, C_NONE);
        check("ifn_flag", 32'(trap), 32'd1);
        check("ifn_cause", 32'(trap_cause), 32'd2);
        do_reset();

        // Counter wrap: 2^CNT_W back-to-back beq retirements return the count to 0
        run = 1'b1; opcode = 6'b000100;
        cyc("wrap_idle", S_IDLE, C_NONE);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("wrap_cnt%0d", i), 32'(instr_count), 32'(i));
            cyc($sformatf("wrap_fetch%0d", i), S_FETCH, C_FETCH);
            cyc($sformatf("wrap_dec%0d", i), S_DECODE, C_NONE);
            Zero = i[0];
            if (i == 15) run = 1'b0;
            cyc($sformatf("wrap_br%0d", i), S_BRANCH, (i % 2 == 1) ? C_BR_T : C_BR_N);
        end
        check("wrap_final", 32'(instr_count), 32'd0);
        check("wrap_state", 32'(o_dbg_state), 32'(S_IDLE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
